decoder_sequencer: RTL and testbench

//  Parametrised, registered 1-of-N decoder with three selectable modes:
//  - DIRECT: decode a loaded address.
//  - STEP: advance the active output on each step pulse.
//  - SCAN: advance automatically every DIV cycles.

---
 rtl/decoder_sequencer.sv | 147 ++++++++++++++
 tb/tb_decoder_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_sequencer
//
// Registered 1-of-N decoder with three ways of moving the active output.
// It is used for digit/row strobing and channel select.
//   DIRECT : the active output is set from a loaded address.
//   STEP   : the active output advances by one on every clock that step is high.
//   SCAN   : the active output advances automatically once every DIV enabled
//            clocks.
//   HOLD   : the active index is frozen.
//
// z is registered from the next-state index, so z and idx change on the same
// edge.
//
// Parameters
//   SEL_W      width of sel/idx (2 <= NUM_OUT <= 2**SEL_W)
//   NUM_OUT    number of decoded outputs; idx wraps NUM_OUT-1 -> 0
//   DIV        SCAN prescale, one advance per DIV enabled clocks (DIV >= 1)
//   ACTIVE_LOW 1 = z asserted low / inactive high (idx, wrap unaffected)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, highest priority
//   en     in   1 = z driven; 0 = z inactive and all state held
//   mode   in   00 DIRECT, 01 STEP, 10 SCAN, 11 HOLD
//   sel    in   DIRECT address, taken when load = 1 and sel < NUM_OUT
//   load   in   DIRECT load strobe
//   step   in   STEP advance level (no edge detection)
//   z      out  registered one-hot decode of idx
//   idx    out  current active index
//   wrap   out  one-cycle pulse on the edge where idx wraps NUM_OUT-1 -> 0
// -----------------------------------------------------------------------------
module decoder_sequencer #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic               step,
  output logic [NUM_OUT-1:0] z,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // The prescaler needs at least one bit even when DIV = 1.
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]     SEL_LIM  = (SEL_W + 1)'(NUM_OUT);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [NUM_OUT-1:0] Z_IDLE   = ACTIVE_LOW ? '1 : '0;

  mode_e              mode_s;
  logic [SEL_W-1:0]   idx_d,  idx_q;
  logic [PRE_W-1:0]   pre_d,  pre_q;
  logic               wrap_d, wrap_q;
  logic [NUM_OUT-1:0] z_d,    z_q;
  logic [SEL_W-1:0]   idx_inc;
  logic               idx_at_last;

  assign mode_s = mode_e'(mode);

  // Shared advance path for STEP and SCAN: wrap back to 0 after NUM_OUT-1.
  assign idx_at_last = (idx_q == IDX_LAST);
  assign idx_inc     = idx_at_last ? '0 : idx_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;

    if (en) begin
      // The prescaler only runs in SCAN; leaving SCAN restarts it at 0.
      pre_d = '0;
      unique case (mode_s)
        MODE_DIRECT: begin
          // Out-of-range addresses are dropped rather than aliased.
          if (load && ({1'b0, sel} < SEL_LIM)) begin
            idx_d = sel;
          end
        end
        MODE_STEP: begin
          if (step) begin
            idx_d  = idx_inc;
            wrap_d = idx_at_last;
          end
        end
        MODE_SCAN: begin
          if (pre_q == PRE_LAST) begin
            idx_d  = idx_inc;
            wrap_d = idx_at_last;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        MODE_HOLD: begin
          idx_d = idx_q;
        end
      endcase
    end

    // Decode the next-state index so z lines up with idx on the same edge.
    z_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      z_d[i] = en && (idx_d == SEL_W'(i));
    end
    if (ACTIVE_LOW) begin
      z_d = ~z_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same point in time.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      z_q    <= Z_IDLE;
    end else begin
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      z_q    <= z_d;
    end
  end

  assign z    = z_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_sequencer
//
// Directed bench for decoder_sequencer. Three instances share one stimulus set:
//   u_d8  : defaults (NUM_OUT=8, DIV=4, active-high z)
//   u_d6  : NUM_OUT=6, exercises the out-of-range load and the wrap at 5
//   u_dal : ACTIVE_LOW=1, DIV=1, exercises inverted z and every-clock scan
// Inputs change 1 time unit after a rising edge, and outputs are sampled there
// as well.
// -----------------------------------------------------------------------------
module tb_decoder_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       load;
  logic       step;

  logic [7:0] z8,   zal;
  logic [5:0] z6;
  logic [2:0] idx8, idx6, idxal;
  logic       wrap8, wrap6, wrapal;

  int n_checks = 0;
  int n_pass   = 0;
  int wraps8;
  int wrapsal;

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_STEP   = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  decoder_sequencer u_d8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .load(load), .step(step), .z(z8), .idx(idx8), .wrap(wrap8)
  );

  decoder_sequencer #(.NUM_OUT(6)) u_d6 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .load(load), .step(step), .z(z6), .idx(idx6), .wrap(wrap6)
  );

  decoder_sequencer #(.DIV(1), .ACTIVE_LOW(1'b1)) u_dal (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .load(load), .step(step), .z(zal), .idx(idxal), .wrap(wrapal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = M_DIRECT; sel = '0; load = 1'b0; step = 1'b0;
    tick(2);
    check("rst_idx",    idx8,  0);
    check("rst_z",      z8,    8'h00);
    check("rst_wrap",   wrap8, 0);
    check("rst_z_al",   zal,   8'hFF);

    // DIRECT loads
    reset = 1'b0; en = 1'b1; load = 1'b1; sel = 3'd5;
    tick();
    check("dir5_idx",   idx8,  5);
    check("dir5_z",     z8,    8'b0010_0000);
    check("dir5_wrap",  wrap8, 0);
    check("dir5_z6",    z6,    6'b10_0000);
    check("dir5_z_al",  zal,   8'hDF);

    sel = 3'd6;
    tick();
    check("dir6_idx",   idx8,  6);
    check("dir6_idx6",  idx6,  5);
    sel = 3'd7;
    tick();
    check("dir7_idx",   idx8,  7);
    check("dir7_z",     z8,    8'h80);
    check("dir7_idx6",  idx6,  5);
    check("dir7_z6",    z6,    6'b10_0000);

    load = 1'b0; sel = 3'd2;
    tick();
    check("noload_idx", idx8,  7);

    // STEP across the wrap
    mode = M_STEP; step = 1'b1;
    tick();
    check("st1_idx",    idx8,  0);
    check("st1_wrap",   wrap8, 1);
    check("st1_z",      z8,    8'h01);
    check("st1_idx6",   idx6,  0);
    check("st1_wrap6",  wrap6, 1);
    tick();
    check("st2_idx",    idx8,  1);
    check("st2_wrap",   wrap8, 0);
    step = 1'b0;
    tick();
    check("st0_idx",    idx8,  1);
    load = 1'b1; sel = 3'd4;
    tick();
    check("st_load_ign", idx8, 1);
    load = 1'b0;

    // HOLD and en gating
    mode = M_HOLD; step = 1'b1;
    tick();
    check("hold_idx",   idx8,  1);
    check("hold_z",     z8,    8'h02);
    en = 1'b0;
    tick();
    check("dis_z",      z8,    8'h00);
    check("dis_idx",    idx8,  1);
    check("dis_z_al",   zal,   8'hFF);
    en = 1'b1;
    tick();
    check("reen_z",     z8,    8'h02);
    step = 1'b0;

    // SCAN from reset for 32 clocks
    reset = 1'b1;
    tick();
    reset = 1'b0; mode = M_SCAN;
    wraps8 = 0; wrapsal = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (wrap8)  wraps8++;
      if (wrapal) wrapsal++;
      if (c == 3) check("scan3_idx", idx8, 0);
      if (c == 4) check("scan4_idx", idx8, 1);
    end
    check("scan32_idx",    idx8,    0);
    check("scan32_wraps",  wraps8,  1);
    check("scan32_wrap",   wrap8,   1);
    check("scan32_idx_al", idxal,   0);
    check("scan32_wraps_al", wrapsal, 4);

    // en gap mid-prescale: prescaler must resume from 2
    tick();
    check("scan_wrap_end", wrap8, 0);
    tick();
    en = 1'b0;
    tick(3);
    check("gap_z",      z8,    8'h00);
    check("gap_idx",    idx8,  0);
    check("gap_wrap",   wrap8, 0);
    en = 1'b1;
    tick();
    check("resume1_idx", idx8, 0);
    tick();
    check("resume2_idx", idx8, 1);
    check("resume2_z",   z8,   8'h02);

    // Reset mid-scan with idx = 3 and prescaler = 2
    tick(8);
    check("pre_rst_idx", idx8, 3);
    tick(2);
    reset = 1'b1;
    tick();
    check("mrst_idx",   idx8,  0);
    check("mrst_z",     z8,    8'h00);
    check("mrst_wrap",  wrap8, 0);
    check("mrst_z_al",  zal,   8'hFF);
    reset = 1'b0;
    tick(3);
    check("post_rst3_idx", idx8, 0);
    check("post_rst3_z",   z8,   8'h01);
    tick();
    check("post_rst4_idx", idx8, 1);

    // Leaving SCAN for one clock restarts the prescaler
    tick(2);
    mode = M_HOLD;
    tick();
    mode = M_SCAN;
    tick(3);
    check("sw3_idx",    idx8,  1);
    tick();
    check("sw4_idx",    idx8,  2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
